hall_monitor: RTL
=================

HALL_MONITOR -- requirements
Module: hall_monitor

Interface
REQ-001 Parameter COUNT_WIDTH, default 8, width of the signed-wrap hall step counter.
REQ-002 Parameter FILTER_LEN, default 4, consecutive identical synchronized samples required to accept a new hall code (range 1..255).
REQ-003 Parameter STALL_TICKS, default 65535, sysclk cycles without an accepted step before stall is flagged.
REQ-004 sysclk  input  1  system clock; all state on its rising edge.
REQ-005 rst_n  input  1  reset; one clock; asynchronous, active-low.
REQ-006 hall_a, hall_b, hall_c  input  1 each  raw asynchronous hall sensor lines.
REQ-007 cnt_load  input  1  single-cycle strobe; load hall_count from cnt_load_val.
REQ-008 cnt_load_val  input  COUNT_WIDTH  value to load.
REQ-009 fault_clr  input  1  single-cycle strobe; clear hall_fault.
REQ-010 hall_state  output  3  filtered code {a,b,c}.
REQ-011 hall_count  output  COUNT_WIDTH  net accepted steps, modulo 2^COUNT_WIDTH.
REQ-012 dir  output  1  direction of last accepted step (1 = forward).
REQ-013 step_pulse  output  1  one-cycle pulse per accepted step.
REQ-014 hall_fault  output  1  sticky fault flag.
REQ-015 stalled  output  1  stall flag (see Configuration).

Function
REQ-016 Each hall line SHALL pass a 2-FF synchronizer; the filter SHALL accept a code only after FILTER_LEN consecutive identical synchronized samples differing from hall_state.
REQ-017 Latency raw edge -> hall_state update SHALL be 2 + FILTER_LEN cycles; step_pulse, hall_count and dir SHALL update in the same cycle as hall_state.
REQ-018 Forward sequence SHALL be 101,100,110,010,011,001, then wrapping to 101.
REQ-019 Accepted code one position forward SHALL increment hall_count (wrapping max->0), set dir=1, pulse step_pulse.
REQ-020 Accepted code one position backward SHALL decrement hall_count (wrapping 0->max), set dir=0, pulse step_pulse.
REQ-021 Accepted code two or three positions away SHALL leave count/dir unchanged, no pulse, set hall_fault.
REQ-022 Accepted code 000 or 111 SHALL update hall_state, set hall_fault, and invalidate the reference position; count unchanged.
REQ-023 First valid code after reset or after an invalid code SHALL establish the reference only: no count change, no pulse, no fault.
REQ-024 cnt_load SHALL set hall_count to cnt_load_val next cycle; load coincident with a step SHALL win and the step's count change SHALL be discarded (dir and step_pulse still update).
REQ-025 fault_clr SHALL clear hall_fault next cycle; a fault event in the same cycle SHALL win (flag stays 1).

Reset
REQ-026 While rst_n=0: synchronizers, filter counter, hall_state=000, hall_count=0, dir=0, step_pulse=0, hall_fault=0, stalled=0, stall counter=0, reference invalid.
REQ-027 Reset deassertion mid-transition SHALL restart filtering from zero; no step is inferred from pre-reset codes.

Configuration
REQ-028 Macro HALL_STALL_DETECT_EN defined: stall counter increments each cycle, saturates at STALL_TICKS, stalled=1 at saturation, counter and stalled clear on an accepted step or cnt_load.
REQ-029 Macro undefined: stall counter absent, stalled tied to 0.

Structure
REQ-030 Shared package hall_pkg SHALL hold the 6-entry forward sequence table, invalid codes 000/111, and the code-to-index constant mapping.
REQ-031 Synchronizer plus filter SHALL be one sub-module hall_filter (parameter FILTER_LEN), instantiated once per block.

Verification
REQ-032 Reset, then drive 101,100,110,010,011,001,101 each held 50 cycles -> hall_count=6, dir=1, six step_pulses (first code is reference only).
REQ-033 From count 0 step backward 101->001 -> hall_count=0xFF, dir=0, one pulse.
REQ-034 Glitch hall_a for FILTER_LEN-1 cycles -> hall_state unchanged, no pulse; hold for FILTER_LEN -> accepted at exactly 2+FILTER_LEN cycles.
REQ-035 Drive 101->110 (skip) -> hall_fault=1, count unchanged; then 111 -> fault held; fault_clr with simultaneous new skip -> hall_fault stays 1.
REQ-036 cnt_load with cnt_load_val=0x42 same cycle as forward step -> hall_count=0x42, step_pulse=1.
REQ-037 With HALL_STALL_DETECT_EN, STALL_TICKS=100, no hall activity -> stalled=1 at cycle 100; one forward step -> stalled=0 next cycle.

Source files
------------

// File: rtl/hall_pkg.sv
// Shared constants for the hall monitor: forward commutation table, invalid codes,
// code-to-position mapping and the modular position-distance helper.
package hall_pkg;

   localparam int SEQ_LEN = 6;

   // Forward order of the hall code {a,b,c}; position i+1 follows position i.
   localparam logic [2:0] FWD_SEQ [SEQ_LEN] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

   localparam logic [2:0] CODE_NONE   = 3'b000;
   localparam logic [2:0] CODE_ALL    = 3'b111;
   localparam logic [2:0] IDX_INVALID = 3'd7;

   // Indexed by raw code, yields its position in FWD_SEQ (IDX_INVALID for 000/111).
   localparam logic [2:0] CODE_TO_IDX [8] = '{3'd7, 3'd5, 3'd3, 3'd4, 3'd1, 3'd0, 3'd2, 3'd7};

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_FWD  = 2'd1,
      STEP_BWD  = 2'd2,
      STEP_SKIP = 2'd3
   } step_kind_e;

   function automatic logic is_invalid(input logic [2:0] code);
      return (code == CODE_NONE) || (code == CODE_ALL);
   endfunction

   // Forward distance from one position to another, modulo SEQ_LEN.
   function automatic logic [2:0] fwd_dist(input logic [2:0] from_idx, input logic [2:0] to_idx);
      logic [3:0] d;
      d = {1'b0, to_idx} + 4'd6 - {1'b0, from_idx};
      if (d >= 4'd6) begin
         d = d - 4'd6;
      end else begin
         d = d;
      end
      return d[2:0];
   endfunction

endpackage

// File: rtl/hall_monitor_if.sv
// Sensor-side and host-side signal bundle of the hall monitor.
interface hall_monitor_if #(
   parameter int COUNT_WIDTH = 8
);
   logic                   hall_a;
   logic                   hall_b;
   logic                   hall_c;
   logic                   cnt_load;
   logic [COUNT_WIDTH-1:0] cnt_load_val;
   logic                   fault_clr;
   logic [2:0]             hall_state;
   logic [COUNT_WIDTH-1:0] hall_count;
   logic                   dir;
   logic                   step_pulse;
   logic                   hall_fault;
   logic                   stalled;

   modport master (
      output hall_a, hall_b, hall_c, cnt_load, cnt_load_val, fault_clr,
      input  hall_state, hall_count, dir, step_pulse, hall_fault, stalled
   );

   modport slave (
      input  hall_a, hall_b, hall_c, cnt_load, cnt_load_val, fault_clr,
      output hall_state, hall_count, dir, step_pulse, hall_fault, stalled
   );
endinterface

// File: rtl/hall_filter.sv
// Two-flop synchronizer plus run-length filter: a code is accepted once it has been
// seen FILTER_LEN consecutive synchronized samples while differing from the held state.
module hall_filter
   import hall_pkg::*;
#(
   parameter int FILTER_LEN = 4
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic [2:0] raw,
   output logic [2:0] state,
   output logic       accept,
   output logic [2:0] code
);

   logic [2:0] sync1_r;
   logic [2:0] sync2_r;
   logic [2:0] cand_r;
   logic [2:0] state_r;
   logic [8:0] run_r;
   logic [8:0] run_next_s;
   logic       accept_s;

   always_comb begin
      run_next_s = 9'd1;
      accept_s   = 1'b0;
      if (sync2_r == cand_r) begin
         run_next_s = run_r + 9'd1;
      end else begin
         run_next_s = 9'd1;
      end
      if ((sync2_r != state_r) && (run_next_s >= 9'(FILTER_LEN))) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // The run counter only grows while the sample differs from the held state.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
         cand_r  <= 3'b000;
         state_r <= 3'b000;
         run_r   <= 9'd0;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
         cand_r  <= sync2_r;
         if ((sync2_r == state_r) || accept_s) begin
            run_r <= 9'd0;
         end else begin
            run_r <= run_next_s;
         end
         if (accept_s) begin
            state_r <= sync2_r;
         end else begin
            state_r <= state_r;
         end
      end
   end

   assign state  = state_r;
   assign accept = accept_s;
   assign code   = sync2_r;

endmodule

// File: rtl/hall_monitor.sv
// Hall sensor monitor: filtered state, signed-wrap step counter, direction and fault flags.
// Optional stall detector enabled by defining HALL_STALL_DETECT_EN.
module hall_monitor
   import hall_pkg::*;
#(
   parameter int COUNT_WIDTH = 8,
   parameter int FILTER_LEN  = 4,
   parameter int STALL_TICKS = 65535
) (
   input  logic           sysclk,
   input  logic           rst_n,
   hall_monitor_if.slave  bus
);

   logic [2:0]             filt_state_s;
   logic                   accept_s;
   logic [2:0]             code_s;
   logic [2:0]             idx_s;
   logic [2:0]             dist_s;
   step_kind_e             kind_s;
   logic                   step_s;
   logic                   fault_ev_s;
   logic                   ref_valid_next_s;
   logic [2:0]             ref_idx_next_s;
   logic                   ref_valid_r;
   logic [2:0]             ref_idx_r;
   logic [COUNT_WIDTH-1:0] count_r;
   logic                   dir_r;
   logic                   pulse_r;
   logic                   fault_r;
   logic                   stalled_s;

   hall_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .raw    ({bus.hall_a, bus.hall_b, bus.hall_c}),
      .state  (filt_state_s),
      .accept (accept_s),
      .code   (code_s)
   );

   // Classify an accepted code against the reference position.
   always_comb begin
      kind_s           = STEP_NONE;
      fault_ev_s       = 1'b0;
      ref_valid_next_s = ref_valid_r;
      ref_idx_next_s   = ref_idx_r;
      idx_s            = CODE_TO_IDX[code_s];
      dist_s           = fwd_dist(ref_idx_r, idx_s);
      if (!accept_s) begin
         kind_s = STEP_NONE;
      end else if (is_invalid(code_s)) begin
         fault_ev_s       = 1'b1;
         ref_valid_next_s = 1'b0;
      end else if (!ref_valid_r) begin
         ref_valid_next_s = 1'b1;
         ref_idx_next_s   = idx_s;
      end else begin
         ref_idx_next_s = idx_s;
         case (dist_s)
            3'd1:    kind_s = STEP_FWD;
            3'd5:    kind_s = STEP_BWD;
            default: begin
               kind_s     = STEP_SKIP;
               fault_ev_s = 1'b1;
            end
         endcase
      end
   end

   assign step_s = (kind_s == STEP_FWD) || (kind_s == STEP_BWD);

   // A load discards the coincident step's count change; a fault event beats fault_clr.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         ref_valid_r <= 1'b0;
         ref_idx_r   <= IDX_INVALID;
         count_r     <= '0;
         dir_r       <= 1'b0;
         pulse_r     <= 1'b0;
         fault_r     <= 1'b0;
      end else begin
         ref_valid_r <= ref_valid_next_s;
         ref_idx_r   <= ref_idx_next_s;
         pulse_r     <= step_s;
         if (bus.cnt_load) begin
            count_r <= bus.cnt_load_val;
         end else if (kind_s == STEP_FWD) begin
            count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
         end else if (kind_s == STEP_BWD) begin
            count_r <= count_r - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
         end else begin
            count_r <= count_r;
         end
         if (step_s) begin
            dir_r <= (kind_s == STEP_FWD);
         end else begin
            dir_r <= dir_r;
         end
         if (fault_ev_s) begin
            fault_r <= 1'b1;
         end else if (bus.fault_clr) begin
            fault_r <= 1'b0;
         end else begin
            fault_r <= fault_r;
         end
      end
   end

`ifdef HALL_STALL_DETECT_EN
   localparam int STALL_W = $clog2(STALL_TICKS + 1);

   logic [STALL_W-1:0] stall_cnt_r;
   logic               stalled_r;

   // Saturating idle counter; any accepted step or count load restarts it.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= '0;
         stalled_r   <= 1'b0;
      end else if (step_s || bus.cnt_load) begin
         stall_cnt_r <= '0;
         stalled_r   <= 1'b0;
      end else if (stall_cnt_r != STALL_W'(STALL_TICKS)) begin
         stall_cnt_r <= stall_cnt_r + STALL_W'(1);
         stalled_r   <= ((stall_cnt_r + STALL_W'(1)) == STALL_W'(STALL_TICKS));
      end else begin
         stall_cnt_r <= stall_cnt_r;
         stalled_r   <= 1'b1;
      end
   end

   assign stalled_s = stalled_r;
`else
   logic unused_stall_s;
   assign unused_stall_s = (STALL_TICKS != 0);
   assign stalled_s      = 1'b0;
`endif

   assign bus.hall_state = filt_state_s;
   assign bus.hall_count = count_r;
   assign bus.dir        = dir_r;
   assign bus.step_pulse = pulse_r;
   assign bus.hall_fault = fault_r;
   assign bus.stalled    = stalled_s;

endmodule
